// File: rtl/din_loader_pkg.sv
// Shared constants for the din_frame_loader slice: geometry, frame codes,
// FSM state encodings and clear-mode codes.
package din_loader_pkg;

    localparam int DATA_BITS   = 451;
    localparam int NBYTES      = 57;
    localparam int LAST_BITS   = DATA_BITS - 8 * (NBYTES - 1);
    localparam int TRIG_CYC    = 4;
    localparam int TIMEOUT_CYC = 65535;

    localparam logic [7:0] HDR      = 8'hA5;
    localparam logic [7:0] CMD_LOAD = 8'h01;
    localparam logic [7:0] CMD_TRIG = 8'h02;
    localparam logic [7:0] CMD_CLR1 = 8'h03;
    localparam logic [7:0] CMD_CLR0 = 8'h04;
    localparam logic [7:0] CMD_NORM = 8'h05;
    localparam logic [7:0] CMD_DUMP = 8'h06;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_CMD     = 3'd1;
    localparam logic [2:0] ST_PAYLOAD = 3'd2;
    localparam logic [2:0] ST_CKSUM   = 3'd3;
    localparam logic [2:0] ST_COMMIT  = 3'd4;
    localparam logic [2:0] ST_TRIGW   = 3'd5;
    localparam logic [2:0] ST_THOLD   = 3'd6;

    localparam logic [1:0] CLR_NORM = 2'b00;
    localparam logic [1:0] CLR_ONE  = 2'b01;
    localparam logic [1:0] CLR_ZERO = 2'b11;

endpackage

// File: rtl/din_frame_loader_if.sv
// Byte-stream valid/ready link from the host receiver into the loader.
interface din_frame_loader_if;

    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;

    modport master (output rx_data, output rx_valid, input rx_ready);
    modport slave  (input rx_data, input rx_valid, output rx_ready);

endinterface

// File: rtl/din_loader_shadow.sv
// Shadow copy of data_reg, written one byte at a time; the last byte only
// carries the low LAST_BITS bits. Running XOR exists only with DIN_LOADER_CKSUM_EN.
module din_loader_shadow
    import din_loader_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 clr_i,
    input  logic                 wr_en_i,
    input  logic [5:0]           wr_idx_i,
    input  logic [7:0]           wr_byte_i,
`ifdef DIN_LOADER_CKSUM_EN
    output logic [7:0]           xor_o,
`endif
    output logic [DATA_BITS-1:0] shadow_o
);

    logic [DATA_BITS-1:0] shadow_q;
    logic [DATA_BITS-1:0] shadow_d;

    // Byte-lane merge of the incoming byte into the shadow image
    always_comb begin
        shadow_d = shadow_q;
        for (int j = 0; j < NBYTES - 1; j++) begin
            if (wr_en_i && (wr_idx_i == 6'(j))) begin
                shadow_d[8*j +: 8] = wr_byte_i;
            end else begin
                shadow_d[8*j +: 8] = shadow_q[8*j +: 8];
            end
        end
        if (wr_en_i && (wr_idx_i == 6'(NBYTES - 1))) begin
            shadow_d[DATA_BITS-1 -: LAST_BITS] = wr_byte_i[LAST_BITS-1:0];
        end else begin
            shadow_d[DATA_BITS-1 -: LAST_BITS] = shadow_q[DATA_BITS-1 -: LAST_BITS];
        end
    end

    // Shadow register with reset and discard
    always_ff @(posedge clk_i) begin
        if (!rst_n_i || clr_i) begin
            shadow_q <= '0;
        end else begin
            shadow_q <= shadow_d;
        end
    end

`ifdef DIN_LOADER_CKSUM_EN
    logic [7:0] xor_q;

    // Checksum accumulates full bytes as received, including masked bits
    always_ff @(posedge clk_i) begin
        if (!rst_n_i || clr_i) begin
            xor_q <= 8'h00;
        end else if (wr_en_i) begin
            xor_q <= xor_q ^ wr_byte_i;
        end else begin
            xor_q <= xor_q;
        end
    end

    assign xor_o = xor_q;
`endif

    assign shadow_o = shadow_q;

endmodule

// File: rtl/din_frame_loader.sv
// Host-side frame parser and double-buffered data register for the 451-bit
// pattern generator. Optional checksum byte: define DIN_LOADER_CKSUM_EN.
module din_frame_loader
    import din_loader_pkg::*;
(
    input  logic                 clk_in,
    input  logic                 rst_n,
    din_frame_loader_if.slave    rx,
    input  logic                 busy,
    output logic [DATA_BITS-1:0] data_reg,
    output logic                 trig,
    output logic                 dump,
    output logic [1:0]           clr_mode,
    output logic                 frame_err,
    output logic                 loaded
);

    localparam logic [15:0] TO_MAX   = 16'(TIMEOUT_CYC - 1);
    localparam logic [5:0]  CNT_LAST = 6'(NBYTES - 1);
    localparam logic [2:0]  TRG_LAST = 3'(TRIG_CYC - 1);

    logic [2:0]           state_q, state_d;
    logic [5:0]           cnt_q, cnt_d;
    logic [15:0]          to_q, to_d;
    logic [2:0]           tcnt_q, tcnt_d;
    logic [DATA_BITS-1:0] data_reg_q, data_reg_d;
    logic [1:0]           clr_mode_q, clr_mode_d;
    logic                 trig_q, trig_d;
    logic                 dump_q, dump_d;
    logic                 frame_err_q, frame_err_d;
    logic                 loaded_q, loaded_d;
    logic                 rx_ready_q, rx_ready_d;

    logic                 accept_s;
    logic                 listen_s;
    logic                 sh_wr_s;
    logic                 sh_clr_s;
    logic [DATA_BITS-1:0] shadow_s;
`ifdef DIN_LOADER_CKSUM_EN
    logic [7:0]           sh_xor_s;
`endif

    assign accept_s = rx.rx_valid & rx_ready_q;
    assign listen_s = (state_q == ST_CMD) || (state_q == ST_PAYLOAD) || (state_q == ST_CKSUM);

    din_loader_shadow u_shadow (
        .clk_i     (clk_in),
        .rst_n_i   (rst_n),
        .clr_i     (sh_clr_s),
        .wr_en_i   (sh_wr_s),
        .wr_idx_i  (cnt_q),
        .wr_byte_i (rx.rx_data),
`ifdef DIN_LOADER_CKSUM_EN
        .xor_o     (sh_xor_s),
`endif
        .shadow_o  (shadow_s)
    );

    // Frame FSM, inter-byte timeout, trigger hold and output next-state
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        to_d        = 16'd0;
        tcnt_d      = tcnt_q;
        data_reg_d  = data_reg_q;
        clr_mode_d  = clr_mode_q;
        trig_d      = trig_q;
        dump_d      = 1'b0;
        frame_err_d = 1'b0;
        loaded_d    = 1'b0;
        sh_wr_s     = 1'b0;
        sh_clr_s    = 1'b0;

        if (listen_s && !accept_s && (to_q == TO_MAX)) begin
            frame_err_d = 1'b1;
            sh_clr_s    = 1'b1;
            state_d     = ST_IDLE;
        end else begin
            if (listen_s && !accept_s) begin
                to_d = to_q + 16'd1;
            end else begin
                to_d = 16'd0;
            end
            case (state_q)
                ST_IDLE: begin
                    if (accept_s && (rx.rx_data == HDR)) begin
                        state_d = ST_CMD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_CMD: begin
                    if (accept_s) begin
                        state_d = ST_IDLE;
                        case (rx.rx_data)
                            CMD_LOAD: begin
                                state_d  = ST_PAYLOAD;
                                cnt_d    = 6'd0;
                                sh_clr_s = 1'b1;
                            end
                            CMD_TRIG: state_d     = ST_TRIGW;
                            CMD_CLR1: clr_mode_d  = CLR_ONE;
                            CMD_CLR0: clr_mode_d  = CLR_ZERO;
                            CMD_NORM: clr_mode_d  = CLR_NORM;
                            CMD_DUMP: dump_d      = 1'b1;
                            default:  frame_err_d = 1'b1;
                        endcase
                    end else begin
                        state_d = ST_CMD;
                    end
                end
                ST_PAYLOAD: begin
                    if (accept_s) begin
                        sh_wr_s = 1'b1;
                        if (cnt_q == CNT_LAST) begin
`ifdef DIN_LOADER_CKSUM_EN
                            state_d = ST_CKSUM;
`else
                            state_d = ST_COMMIT;
`endif
                        end else begin
                            cnt_d = cnt_q + 6'd1;
                        end
                    end else begin
                        state_d = ST_PAYLOAD;
                    end
                end
`ifdef DIN_LOADER_CKSUM_EN
                ST_CKSUM: begin
                    if (accept_s && (rx.rx_data == sh_xor_s)) begin
                        state_d = ST_COMMIT;
                    end else if (accept_s) begin
                        frame_err_d = 1'b1;
                        sh_clr_s    = 1'b1;
                        state_d     = ST_IDLE;
                    end else begin
                        state_d = ST_CKSUM;
                    end
                end
`endif
                ST_COMMIT: begin
                    // data_reg may only move while the generator is idle
                    if (!busy) begin
                        data_reg_d = shadow_s;
                        loaded_d   = 1'b1;
                        state_d    = ST_IDLE;
                    end else begin
                        state_d = ST_COMMIT;
                    end
                end
                ST_TRIGW: begin
                    if (!busy) begin
                        trig_d  = 1'b1;
                        tcnt_d  = 3'd0;
                        state_d = ST_THOLD;
                    end else begin
                        state_d = ST_TRIGW;
                    end
                end
                ST_THOLD: begin
                    if (tcnt_q == TRG_LAST) begin
                        trig_d  = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        tcnt_d = tcnt_q + 3'd1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        rx_ready_d = (state_d == ST_IDLE) || (state_d == ST_CMD) ||
                     (state_d == ST_PAYLOAD) || (state_d == ST_CKSUM);
    end

    // State and output registers
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 6'd0;
            to_q        <= 16'd0;
            tcnt_q      <= 3'd0;
            data_reg_q  <= '0;
            clr_mode_q  <= CLR_NORM;
            trig_q      <= 1'b0;
            dump_q      <= 1'b0;
            frame_err_q <= 1'b0;
            loaded_q    <= 1'b0;
            rx_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            to_q        <= to_d;
            tcnt_q      <= tcnt_d;
            data_reg_q  <= data_reg_d;
            clr_mode_q  <= clr_mode_d;
            trig_q      <= trig_d;
            dump_q      <= dump_d;
            frame_err_q <= frame_err_d;
            loaded_q    <= loaded_d;
            rx_ready_q  <= rx_ready_d;
        end
    end

    assign rx.rx_ready = rx_ready_q;
    assign data_reg    = data_reg_q;
    assign clr_mode    = clr_mode_q;
    assign trig        = trig_q;
    assign dump        = dump_q;
    assign frame_err   = frame_err_q;
    assign loaded      = loaded_q;

endmodule

// File: tb/tb_din_frame_loader.sv
// Directed bench for din_frame_loader: command table plus hand-written
// load, busy-stall, trigger, timeout and reset sequences.
module tb_din_frame_loader;

    logic         clk_in;
    logic         rst_n;
    logic         busy;
    logic [450:0] data_reg;
    logic         trig;
    logic         dump;
    logic [1:0]   clr_mode;
    logic         frame_err;
    logic         loaded;

    din_frame_loader_if rx_if ();

    din_frame_loader dut (
        .clk_in    (clk_in),
        .rst_n     (rst_n),
        .rx        (rx_if),
        .busy      (busy),
        .data_reg  (data_reg),
        .trig      (trig),
        .dump      (dump),
        .clr_mode  (clr_mode),
        .frame_err (frame_err),
        .loaded    (loaded)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [7:0] b0;
        logic [7:0] b1;
        logic [1:0] exp_clr;
        logic       exp_dump;
        logic       exp_err;
    } vec_t;

    vec_t tbl [7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic chk_wide(input string name, input logic [450:0] act, input logic [450:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Called at posedge+1; returns at posedge+1 just after the byte is taken.
    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        rx_if.rx_data  = b;
        rx_if.rx_valid = 1'b1;
        @(negedge clk_in);
        while (!rx_if.rx_ready && n < 200) begin
            @(negedge clk_in);
            n++;
        end
        if (!rx_if.rx_ready) begin
            n_total++;
            $display("FAIL send_timeout: byte %0h not accepted, rx_ready stays %0b want 1", b, rx_if.rx_ready);
        end
        @(posedge clk_in);
        #1;
        rx_if.rx_valid = 1'b0;
    endtask

    // Sends header, LOAD and 57 bytes f(i); returns the expected data_reg image.
    task automatic send_load(input int mul, input int add, output logic [450:0] img);
        logic [455:0] full;
        logic [7:0]   b;
        logic [7:0]   x;
        full = '0;
        x    = 8'h00;
        send(8'hA5);
        send(8'h01);
        for (int i = 0; i < 57; i++) begin
            b = 8'(i * mul + add);
            full[8*i +: 8] = b;
            x = x ^ b;
            send(b);
        end
`ifdef DIN_LOADER_CKSUM_EN
        send(x);
`endif
        img = full[450:0];
        img[450:448] = full[450:448];
    endtask

    initial begin
        logic [450:0] exp1;
        logic [450:0] exp2;
        logic         bad;
        int           cnt;
        int           n;

        tbl[0] = '{8'hA5, 8'h03, 2'b01, 1'b0, 1'b0};
        tbl[1] = '{8'hA5, 8'h05, 2'b00, 1'b0, 1'b0};
        tbl[2] = '{8'hA5, 8'h04, 2'b11, 1'b0, 1'b0};
        tbl[3] = '{8'hA5, 8'h07, 2'b11, 1'b0, 1'b1};
        tbl[4] = '{8'hA5, 8'h06, 2'b11, 1'b1, 1'b0};
        tbl[5] = '{8'hA5, 8'h00, 2'b11, 1'b0, 1'b1};
        tbl[6] = '{8'hA5, 8'h05, 2'b00, 1'b0, 1'b0};

        rst_n          = 1'b0;
        busy           = 1'b0;
        rx_if.rx_data  = 8'h00;
        rx_if.rx_valid = 1'b0;
        repeat (2) @(posedge clk_in);
        #1;
        chk_wide("reset_data_reg", data_reg, '0);
        chk("reset_outputs", {clr_mode, trig, dump, frame_err, loaded, rx_if.rx_ready}, 64'h0);
        rst_n = 1'b1;
        @(posedge clk_in);
        #1;
        chk("ready_after_reset", rx_if.rx_ready, 64'h1);

        // Noise before a header is dropped silently
        send(8'h11);
        send(8'h22);
        send(8'hA5);
        send(8'h04);
        chk("noise_then_clr0", {clr_mode, frame_err}, {61'h0, 2'b11, 1'b0});
        @(posedge clk_in);
        #1;

        for (int v = 0; v < 7; v++) begin
            send(tbl[v].b0);
            send(tbl[v].b1);
            chk($sformatf("tbl%0d_clr", v), clr_mode, 64'(tbl[v].exp_clr));
            chk($sformatf("tbl%0d_dump", v), dump, 64'(tbl[v].exp_dump));
            chk($sformatf("tbl%0d_err", v), frame_err, 64'(tbl[v].exp_err));
            @(posedge clk_in);
            #1;
            chk($sformatf("tbl%0d_pulse_end", v), {dump, frame_err}, 64'h0);
        end

        // LOAD 00..38h with generator idle
        send_load(1, 0, exp1);
        chk("load1_not_yet", {loaded, 1'b0}, 64'h0);
        chk_wide("load1_old_data", data_reg, '0);
        @(posedge clk_in);
        #1;
        chk("load1_loaded", loaded, 64'h1);
        chk_wide("load1_data", data_reg, exp1);
        chk("load1_byte0", data_reg[7:0], 64'h00);
        chk("load1_byte1", data_reg[15:8], 64'h01);
        chk("load1_top3", data_reg[450:448], 64'h0);
        @(posedge clk_in);
        #1;
        chk("load1_pulse_end", loaded, 64'h0);

        // LOAD held off by busy for 100 cycles
        busy = 1'b1;
        send_load(3, 7, exp2);
        bad = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk_in);
            #1;
            if (rx_if.rx_ready || loaded || (data_reg !== exp1)) bad = 1'b1;
        end
        chk("load2_hold_while_busy", bad, 64'h0);
        busy = 1'b0;
        @(posedge clk_in);
        #1;
        chk("load2_loaded", loaded, 64'h1);
        chk_wide("load2_data", data_reg, exp2);
        chk("load2_top3", data_reg[450:448], 64'h7);

        // TRIG waits for busy to drop, then holds 4 cycles
        busy = 1'b1;
        send(8'hA5);
        send(8'h02);
        bad = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk_in);
            #1;
            if (trig) bad = 1'b1;
        end
        chk("trig_low_while_busy", bad, 64'h0);
        busy = 1'b0;
        cnt  = 0;
        @(posedge clk_in);
        #1;
        chk("trig_first_cycle", trig, 64'h1);
        if (trig) cnt++;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk_in);
            #1;
            if (trig) cnt++;
        end
        chk("trig_width", 64'(cnt), 64'd4);

        // DUMP is honoured while the generator is busy
        busy = 1'b1;
        send(8'hA5);
        send(8'h06);
        chk("dump_busy_pulse", dump, 64'h1);
        @(posedge clk_in);
        #1;
        chk("dump_busy_end", dump, 64'h0);
        busy = 1'b0;

`ifdef DIN_LOADER_CKSUM_EN
        send(8'hA5);
        send(8'h01);
        for (int i = 0; i < 57; i++) send(8'h5A);
        send(8'h01);
        chk("cksum_bad_err", frame_err, 64'h1);
        @(posedge clk_in);
        #1;
        chk("cksum_bad_noload", loaded, 64'h0);
        chk_wide("cksum_bad_data", data_reg, exp2);
`endif

        // Stalled LOAD times out after 65535 idle cycles
        send(8'hA5);
        send(8'h01);
        for (int i = 0; i < 10; i++) send(8'hC3);
        n = 0;
        while (!frame_err && n < 70000) begin
            @(negedge clk_in);
            n++;
        end
        chk("timeout_cycles", 64'(n), 64'd65536);
        @(posedge clk_in);
        #1;
        chk_wide("timeout_data_kept", data_reg, exp2);
        chk("timeout_idle", {rx_if.rx_ready, loaded}, 64'h2);

        // Reset in the middle of a payload
        send(8'hA5);
        send(8'h03);
        send(8'hA5);
        send(8'h01);
        for (int i = 0; i < 5; i++) send(8'h99);
        rst_n = 1'b0;
        @(posedge clk_in);
        #1;
        chk_wide("midrst_data", data_reg, '0);
        chk("midrst_outputs", {clr_mode, rx_if.rx_ready}, 64'h0);
        rst_n = 1'b1;
        @(posedge clk_in);
        #1;
        send(8'h01);
        send(8'hA5);
        send(8'h03);
        chk("midrst_idle_then_clr1", clr_mode, 64'h1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
